if_fetch_ctrl: RTL and testbench
================================

// Module: if_fetch_ctrl
// PURPOSE
//  Fetch sequencer in front of the IF stage register of the ARM pipeline.
//  Owns the program counter and issues requests to a variable-latency
//  instruction memory (req/ready). Drives PCIn/instructionIn and the
//  freeze/flush controls of the IF stage register. Arbitrates taken
//  branches from EX against load-use stalls from the hazard unit.
// PARAMETERS
//  RESET_PC    32'h0  PC value loaded on reset
//  WAIT_LIMIT  255    max consecutive wait cycles before fetch_err (8-bit counter)
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous, active-low reset
//  hazard       in   1   ID stall request from hazard unit
//  branch_taken in   1   EX redirect, single-cycle pulse
//  branch_addr  in   32  redirect target
//  imem_ready   in   1   memory returns data this cycle
//  imem_rdata   in   32  instruction word, valid with imem_ready
//  imem_req     out  1   fetch request, held until imem_ready
//  imem_addr    out  32  fetch address, stable while imem_req=1
//  if_pc        out  32  to IF reg PCIn: fetched address + 4
//  if_instr     out  32  to IF reg instructionIn
//  if_freeze    out  1   to IF reg freeze
//  if_flush     out  1   to IF reg flush (inserts NOP bubble)
//  fetch_err    out  1   sticky watchdog flag, cleared only by reset
// BEHAVIOUR
//  States: BOOT, FETCH, HOLD, DRAIN. rst=0 -> BOOT, pc=RESET_PC, req_addr=0,
//   hold_buf=0, wait_cnt=0, fetch_err=0.
//  Outputs are combinational from state/inputs. Defaults: imem_req=0,
//   if_freeze=0, if_flush=0, if_pc=req_addr+4, if_instr=0.
//  BOOT: if_flush=1; next FETCH (exactly one cycle after rst release).
//  FETCH: imem_req=1, imem_addr=pc; req_addr<=pc on entry, held while waiting.
//   ready & branch_taken: discard data, pc<=branch_addr, if_flush=1, stay FETCH.
//   ready & hazard: hold_buf<=imem_rdata, if_freeze=1, pc unchanged -> HOLD.
//   ready only: if_instr=imem_rdata, if_pc=pc+4, pc<=pc+4 (0-cycle latency).
//   !ready & branch_taken: pc<=branch_addr, if_flush=1 -> DRAIN.
//   !ready & hazard: if_freeze=1 (ID stalled, IF reg held).
//   !ready otherwise: if_flush=1 (bubble).
//  HOLD: imem_req=0. branch_taken: drop hold_buf, pc<=branch_addr,
//   if_flush=1 -> FETCH. hazard: if_freeze=1, stay. else: if_instr=hold_buf,
//   if_pc=pc+4, pc<=pc+4 -> FETCH.
//  DRAIN: outstanding request cannot be cancelled; imem_req=1,
//   imem_addr=req_addr, if_flush=1 every cycle. branch_taken again:
//   pc<=branch_addr (latest wins). ready: discard data -> FETCH.
//  Priority: branch_taken > hazard > normal (flush overrides freeze);
//   if_freeze and if_flush never both 1.
//  PC arithmetic mod 2^32: 32'hFFFFFFFC+4 wraps to 0, no flag.
//  Watchdog: wait_cnt increments each FETCH/DRAIN cycle with imem_req=1 and
//   !imem_ready, clears on ready or state exit, saturates; wait_cnt==WAIT_LIMIT
//   sets fetch_err. Fetch continues.
//  Reset mid-request: state->BOOT immediately; memory must drop the request.
// TESTING
//  1 Reset, ready tied 1, rdata=32'hE3A00001: BOOT flush 1 cycle; then
//    if_pc=4,8,12 on consecutive cycles, freeze=flush=0.
//  2 ready 0 for 3 cycles at pc=8: imem_addr=8 stable, flush=1 x3; on
//    ready if_instr=rdata, if_pc=12.
//  3 hazard=1 with ready at pc=16: freeze=1, HOLD 2 cycles, req=0; hazard
//    drop -> if_instr=held word, if_pc=20, next imem_addr=20.
//  4 branch_taken=1, branch_addr=32'h100, ready 0 at pc=24: DRAIN, flush=1,
//    imem_addr=24 until ready; then FETCH with imem_addr=32'h100.
//  5 branch_taken and hazard together in HOLD: flush=1, freeze=0, pc=branch_addr.
//  6 ready stuck 0 with WAIT_LIMIT=4: fetch_err=1 after 4 wait cycles; stays
//    1 until rst=0; pc=32'hFFFFFFFC fetch -> if_pc=0.

Source files
------------

// File: rtl/imem_if.sv
// Instruction memory request/ready bus.
// Master issues req/addr; slave answers with ready/rdata.
interface imem_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (
    output req, addr,
    input  ready, rdata
  );

  modport slave (
    input  req, addr,
    output ready, rdata
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Fetch sequencer: owns the PC, talks to imem,
// and drives PCIn/instruction/freeze/flush of the IF reg.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  imem_if.master      imem,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_freeze,
  output logic        if_flush,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    BOOT, FETCH, HOLD, DRAIN
  } state_t;

  localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] req_addr, req_n;
  logic [31:0] hold_buf, hold_n;
  logic [7:0]  wait_cnt, cnt_n, cnt_inc;
  logic        err_q;
  logic        lim_hit;
  logic [31:0] pc4;

  assign pc4      = pc + 32'd4;
  assign cnt_inc  = (wait_cnt == 8'hFF) ? wait_cnt
                                        : wait_cnt + 8'd1;
  assign lim_hit  = (wait_cnt == LIMIT);
  assign fetch_err = err_q | lim_hit;

  // State, PC, capture buffers and sticky watchdog flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      req_addr <= 32'h0;
      hold_buf <= 32'h0;
      wait_cnt <= 8'h0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      req_addr <= req_n;
      hold_buf <= hold_n;
      wait_cnt <= cnt_n;
      err_q    <= err_q | lim_hit;
    end
  end

  // Next state and IF-reg/imem controls; branch beats hazard.
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    req_n     = req_addr;
    hold_n    = hold_buf;
    cnt_n     = 8'h0;
    imem.req  = 1'b0;
    imem.addr = pc;
    if_freeze = 1'b0;
    if_flush  = 1'b0;
    if_pc     = req_addr + 32'd4;
    if_instr  = 32'h0;
    unique case (state)
      BOOT: begin
        if_flush = 1'b1;
        state_n  = FETCH;
      end
      FETCH: begin
        imem.req = 1'b1;
        req_n    = pc;
        if (imem.ready) begin
          if (branch_taken) begin
            pc_n     = branch_addr;
            if_flush = 1'b1;
          end else if (hazard) begin
            hold_n    = imem.rdata;
            if_freeze = 1'b1;
            state_n   = HOLD;
          end else begin
            if_instr = imem.rdata;
            if_pc    = pc4;
            pc_n     = pc4;
          end
        end else if (branch_taken) begin
          pc_n     = branch_addr;
          if_flush = 1'b1;
          state_n  = DRAIN;
        end else begin
          cnt_n = cnt_inc;
          if (hazard) if_freeze = 1'b1;
          else        if_flush  = 1'b1;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_n     = branch_addr;
          if_flush = 1'b1;
          state_n  = FETCH;
        end else if (hazard) begin
          if_freeze = 1'b1;
        end else begin
          if_instr = hold_buf;
          if_pc    = pc4;
          pc_n     = pc4;
          state_n  = FETCH;
        end
      end
      DRAIN: begin
        imem.req  = 1'b1;
        imem.addr = req_addr;
        if_flush  = 1'b1;
        if (branch_taken) pc_n = branch_addr;
        if (imem.ready) state_n = FETCH;
        else            cnt_n   = cnt_inc;
      end
      default: state_n = BOOT;
    endcase
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with a
// per-cycle expectation queue and a negedge monitor.
module tb_if_fetch_ctrl;

  localparam logic [31:0] R0 = 32'hE3A00001;
  localparam logic [31:0] R1 = 32'hE2811001;
  localparam logic [31:0] R2 = 32'hE5912000;
  localparam logic [31:0] TOP = 32'hFFFFFFFC;

  typedef struct {
    int          id;
    logic        req;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        frz;
    logic        fl;
    logic        err;
    logic [2:0]  care;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        hazard;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_freeze;
  logic        if_flush;
  logic        fetch_err;

  imem_if bus ();

  if_fetch_ctrl #(
    .RESET_PC  (32'h0),
    .WAIT_LIMIT(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .hazard      (hazard),
    .branch_taken(branch_taken),
    .branch_addr (branch_addr),
    .imem        (bus.master),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .if_freeze   (if_freeze),
    .if_flush    (if_flush),
    .fetch_err   (fetch_err)
  );

  exp_t q[$];
  int   n_run  = 0;
  int   n_fail = 0;
  int   step   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t E(
    input logic        rq,
    input logic [31:0] a,
    input logic [31:0] p,
    input logic [31:0] i,
    input logic        fz,
    input logic        fl,
    input logic        er,
    input logic [2:0]  c
  );
    exp_t e;
    e.id    = 0;
    e.req   = rq;
    e.addr  = a;
    e.pc    = p;
    e.instr = i;
    e.frz   = fz;
    e.fl    = fl;
    e.err   = er;
    e.care  = c;
    return e;
  endfunction

  task automatic chk(
    input int          id,
    input string       nm,
    input logic [31:0] got,
    input logic [31:0] want
  );
    n_run++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL step%0d %s got %h want %h",
               id, nm, got, want);
    end
  endtask

  task automatic cyc(
    input logic        r,
    input logic        rdy,
    input logic        hz,
    input logic        br,
    input logic [31:0] ba,
    input logic [31:0] rd,
    input exp_t        e
  );
    rst          = r;
    bus.ready    = rdy;
    hazard       = hz;
    branch_taken = br;
    branch_addr  = ba;
    bus.rdata    = rd;
    e.id = step;
    step++;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT outputs against the queued expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk(e.id, "imem_req", 32'(bus.req), 32'(e.req));
      chk(e.id, "if_freeze", 32'(if_freeze), 32'(e.frz));
      chk(e.id, "if_flush", 32'(if_flush), 32'(e.fl));
      chk(e.id, "fetch_err", 32'(fetch_err), 32'(e.err));
      if (e.care[2]) chk(e.id, "imem_addr", bus.addr, e.addr);
      if (e.care[1]) chk(e.id, "if_pc", if_pc, e.pc);
      if (e.care[0]) chk(e.id, "if_instr", if_instr, e.instr);
    end
  end

  initial begin
    rst          = 1'b1;
    hazard       = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = 32'h0;
    bus.ready    = 1'b0;
    bus.rdata    = 32'h0;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    // reset state, then single BOOT flush cycle
    cyc(0, 0,0,0, 0, 0,  E(0, 0, 4, 0, 0,1,0, 3'b011));
    cyc(1, 1,0,0, 0, R0, E(0, 0, 0, 0, 0,1,0, 3'b001));
    // streaming fetch, zero latency
    cyc(1, 1,0,0, 0, R0, E(1, 0, 4, R0, 0,0,0, 3'b111));
    cyc(1, 1,0,0, 0, R0, E(1, 4, 8, R0, 0,0,0, 3'b111));
    // wait states at pc=8
    repeat (3)
      cyc(1, 0,0,0, 0, R0, E(1, 8, 0, 0, 0,1,0, 3'b101));
    cyc(1, 1,0,0, 0, R1, E(1, 8, 12, R1, 0,0,0, 3'b111));
    cyc(1, 1,0,0, 0, R0, E(1, 12, 16, R0, 0,0,0, 3'b111));
    // hazard with data -> HOLD
    cyc(1, 1,1,0, 0, R2, E(1, 16, 0, 0, 1,0,0, 3'b101));
    repeat (2)
      cyc(1, 0,1,0, 0, 0, E(0, 0, 0, 0, 1,0,0, 3'b001));
    cyc(1, 0,0,0, 0, 0, E(0, 0, 20, R2, 0,0,0, 3'b011));
    cyc(1, 1,0,0, 0, R0, E(1, 20, 24, R0, 0,0,0, 3'b111));
    // branch while request outstanding -> DRAIN
    cyc(1, 0,0,1, 32'h100, 0, E(1, 24, 0, 0, 0,1,0, 3'b101));
    repeat (2)
      cyc(1, 0,0,0, 0, 0, E(1, 24, 0, 0, 0,1,0, 3'b101));
    cyc(1, 1,0,0, 0, R1, E(1, 24, 0, 0, 0,1,0, 3'b101));
    cyc(1, 1,0,0, 0, R0,
        E(1, 32'h100, 32'h104, R0, 0,0,0, 3'b111));
    // branch with ready: data dropped, stay in FETCH
    cyc(1, 1,0,1, 32'h300, R1,
        E(1, 32'h104, 0, 0, 0,1,0, 3'b101));
    cyc(1, 1,0,0, 0, R0,
        E(1, 32'h300, 32'h304, R0, 0,0,0, 3'b111));
    // branch and hazard together in HOLD
    cyc(1, 1,1,0, 0, R2, E(1, 32'h304, 0, 0, 1,0,0, 3'b101));
    cyc(1, 0,1,1, 32'h400, 0, E(0, 0, 0, 0, 0,1,0, 3'b001));
    cyc(1, 1,0,0, 0, R0,
        E(1, 32'h400, 32'h404, R0, 0,0,0, 3'b111));
    // hazard while waiting: freeze, not flush
    cyc(1, 0,1,0, 0, 0, E(1, 32'h404, 0, 0, 1,0,0, 3'b101));
    cyc(1, 1,0,0, 0, R1,
        E(1, 32'h404, 32'h408, R1, 0,0,0, 3'b111));
    // watchdog: limit 4 wait cycles
    repeat (4)
      cyc(1, 0,0,0, 0, 0, E(1, 32'h408, 0, 0, 0,1,0, 3'b101));
    cyc(1, 0,0,0, 0, 0, E(1, 32'h408, 0, 0, 0,1,1, 3'b101));
    cyc(1, 1,0,0, 0, R0,
        E(1, 32'h408, 32'h40C, R0, 0,0,1, 3'b111));
    // PC wrap at top of address space
    cyc(1, 1,0,1, TOP, R1, E(1, 32'h40C, 0, 0, 0,1,1, 3'b101));
    cyc(1, 1,0,0, 0, R0, E(1, TOP, 0, R0, 0,0,1, 3'b111));
    cyc(1, 1,0,0, 0, R0, E(1, 0, 4, R0, 0,0,1, 3'b111));
    // reset mid-request clears everything
    cyc(1, 0,0,0, 0, 0, E(1, 4, 0, 0, 0,1,1, 3'b101));
    cyc(0, 0,0,0, 0, 0, E(0, 0, 4, 0, 0,1,0, 3'b011));
    cyc(1, 1,0,0, 0, R0, E(0, 0, 0, 0, 0,1,0, 3'b001));
    cyc(1, 1,0,0, 0, R0, E(1, 0, 4, R0, 0,0,0, 3'b111));
    repeat (3) @(negedge clk);
    #1;
    n_run++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain left %0d want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
